sdram_refresh_scheduler: RTL and testbench

Sequences SDRAM auto-refresh cycles and shares the command bus between refresh and a single user access port. It sits between `refresh_timer` (whose `REFRESH_STROBE` it consumes) and the SDRAM command issuer. Refreshes are taken opportunistically when the user port is idle, postponed while the user holds the bus, and forced once enough are owed. Owed refreshes are tracked in a saturating debt counter.

---
 rtl/sdram_refresh_scheduler_pkg.sv | 7 +
 rtl/sdram_refresh_scheduler_if.sv | 19 +
 rtl/sdram_refresh_scheduler_rise_detect.sv | 13 +
 rtl/sdram_refresh_scheduler.sv | 88 ++++++++
 tb/tb_sdram_refresh_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sdram_refresh_scheduler_pkg.sv
// sdram_pkg: shared FSM states, debt width and default SDRAM refresh timings
package sdram_pkg;
    typedef enum logic [2:0] {IDLE, GRANT, PRE, WAIT_RP, REF, WAIT_RFC} state_e;
    localparam int DEBT_W = 4;
    localparam int T_RP_DEF = 3;
    localparam int T_RFC_DEF = 10;
endpackage

// File: rtl/sdram_refresh_scheduler_if.sv
// sdram_refresh_scheduler_if: control, user handshake and command signals of the refresh scheduler
interface sdram_refresh_scheduler_if;
    logic enable;
    logic refresh_strobe;
    logic user_req;
    logic user_gnt;
    logic cmd_precharge_all;
    logic cmd_refresh;
    logic [sdram_pkg::DEBT_W-1:0] debt;
    logic overflow;
    modport master (
        output enable, refresh_strobe, user_req,
        input  user_gnt, cmd_precharge_all, cmd_refresh, debt, overflow
    );
    modport slave (
        input  enable, refresh_strobe, user_req,
        output user_gnt, cmd_precharge_all, cmd_refresh, debt, overflow
    );
endinterface

// File: rtl/sdram_refresh_scheduler_rise_detect.sv
// rise_detect: one-cycle pulse on each rising edge of a level input
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_i;
    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/sdram_refresh_scheduler.sv
// sdram_refresh_scheduler: arbitrates the SDRAM command bus between auto-refresh and one user port,
// tracking owed refreshes in a saturating debt counter
module sdram_refresh_scheduler
    import sdram_pkg::*;
#(
    parameter int T_RP        = T_RP_DEF,
    parameter int T_RFC       = T_RFC_DEF,
    parameter int MAX_DEBT    = 8,
    parameter int URGENT_DEBT = 4
) (
    input logic clk,
    input logic rst_n,
    sdram_refresh_scheduler_if.slave bus
);
    localparam int CW = $clog2((T_RP > T_RFC ? T_RP : T_RFC) + 1);
    localparam logic [CW-1:0] RP_L = CW'(T_RP - 1);
    localparam logic [CW-1:0] RFC_L = CW'(T_RFC - 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [DEBT_W-1:0] MAXD = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] URG = DEBT_W'(URGENT_DEBT);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DEBT_W-1:0] debt_q, debt_d, debt_post;
    logic ovf_q, ovf_d, rise, inc, dec, again;

    rise_detect u_rise (.clk(clk), .rst_n(rst_n), .d_i(bus.refresh_strobe), .rise_o(rise));

    assign inc = rise & bus.enable;
    assign dec = state_q == REF;
    // back-to-back refresh decision uses the debt as it stands once the current REF is counted
    assign debt_post = debt_q - DEBT_W'(dec);
    assign again = debt_post != '0 && (!bus.user_req || debt_post >= URG);

    always_comb begin
        debt_d = !bus.enable ? '0 :
                 inc && !dec ? (debt_q == MAXD ? debt_q : debt_q + 1'b1) :
                 dec && !inc ? debt_q - 1'b1 : debt_q;
        ovf_d = ovf_q | (inc & (debt_q == MAXD));
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE:     state_d = bus.user_req && debt_q < URG ? GRANT :
                                bus.enable && debt_q != '0 ? PRE : IDLE;
            GRANT:    state_d = bus.user_req ? GRANT : IDLE;
            PRE: begin
                cnt_d = RP_L;
                state_d = T_RP == 1 ? REF : WAIT_RP;
            end
            WAIT_RP: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) state_d = REF;
            end
            REF: begin
                cnt_d = RFC_L;
                state_d = T_RFC > 1 ? WAIT_RFC : again ? REF : IDLE;
            end
            WAIT_RFC: begin
                cnt_d = cnt_q - ONE;
                if (cnt_q == ONE) state_d = again ? REF : IDLE;
            end
            default:  state_d = IDLE;
        endcase
        if (!bus.enable && state_q inside {PRE, WAIT_RP, REF, WAIT_RFC}) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            debt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            debt_q <= debt_d;
            ovf_q <= ovf_d;
        end

    assign bus.user_gnt = state_q == GRANT;
    assign bus.cmd_precharge_all = state_q == PRE;
    assign bus.cmd_refresh = state_q == REF;
    assign bus.debt = debt_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_sdram_refresh_scheduler.sv
// tb_sdram_refresh_scheduler: directed refresh/arbitration scenarios checked against a timeline model
module tb_sdram_refresh_scheduler;
    localparam int TRP = 3, TRFC = 10, MAXD = 8, URG = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int total = 0, bad = 0;
    int npre, nref, tg, tp, tr, cnt;

    always #5 clk = ~clk;

    sdram_refresh_scheduler_if bus();
    sdram_refresh_scheduler #(.T_RP(TRP), .T_RFC(TRFC), .MAX_DEBT(MAXD), .URGENT_DEBT(URG))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // model: mode 0 idle, 1 granted, 2 refresh sequence; m_k counts cycles since PRE, m_next is the next REF slot
    int m_mode, m_k, m_next, m_nref, m_debt, m_dpost;
    bit m_ovf, m_sprev, m_inc, m_rf;
    logic [7:0] c_got, c_exp;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_k = 0; m_next = 0; m_nref = 0; m_debt = 0; m_ovf = 0; m_sprev = 0;
        end else begin
            m_inc = bus.enable && bus.refresh_strobe && !m_sprev;
            m_rf = m_mode == 2 && m_k == m_next;
            m_dpost = m_debt - (m_rf ? 1 : 0);
            m_sprev = bus.refresh_strobe;
            if (m_inc && m_debt == MAXD) m_ovf = 1;
            if (m_mode == 0) begin
                if (bus.user_req && m_debt < URG) m_mode = 1;
                else if (bus.enable && m_debt > 0) begin
                    m_mode = 2; m_k = 0; m_next = TRP; m_nref = 0;
                end
            end else if (m_mode == 1) begin
                if (!bus.user_req) m_mode = 0;
            end else if (!bus.enable) m_mode = 0;
            else begin
                if (m_rf) begin m_next = m_k + TRFC; m_nref++; end
                m_k++;
                if (m_k == m_next && m_nref > 0 && !(m_dpost > 0 && (!bus.user_req || m_dpost >= URG)))
                    m_mode = 0;
            end
            if (!bus.enable) m_debt = 0;
            else if (m_inc && !m_rf) m_debt = m_debt == MAXD ? MAXD : m_debt + 1;
            else if (m_rf && !m_inc) m_debt--;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            c_got = {bus.user_gnt, bus.cmd_precharge_all, bus.cmd_refresh, bus.overflow, bus.debt};
            c_exp = {m_mode == 1, m_mode == 2 && m_k == 0, m_mode == 2 && m_k == m_next, m_ovf, 4'(m_debt)};
            total++;
            if (c_got !== c_exp) begin
                bad++;
                $display("FAIL cycle_model t=%0t gnt/pre/ref/ovf/debt got=%b exp=%b", $time, c_got, c_exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic edges(int n);
        repeat (n) begin
            bus.refresh_strobe = 1'b1; tick(2);
            bus.refresh_strobe = 1'b0; tick(2);
        end
    endtask

    task automatic wait_ref(string nm);
        int i;
        for (i = 0; i < 200 && !bus.cmd_refresh; i++) tick(1);
        chk(nm, i < 200, 1);
    endtask

    task automatic run(int n);
        npre = 0; nref = 0; tg = -1; tp = -1; tr = -1;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (bus.cmd_precharge_all) begin npre++; tp = i; end
            if (bus.cmd_refresh) begin
                if (nref > 0) chk("ref_to_ref", i - tr, TRFC);
                else if (tp >= 0) chk("pre_to_ref", i - tp, TRP);
                tr = i; nref++;
            end
            if (bus.user_gnt && tg < 0) tg = i;
        end
    endtask

    initial begin
        bus.enable = 1'b1; bus.refresh_strobe = 1'b0; bus.user_req = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_gnt", bus.user_gnt, 0);
        chk("rst_pre", bus.cmd_precharge_all, 0);
        chk("rst_ref", bus.cmd_refresh, 0);
        chk("rst_debt", bus.debt, 0);
        chk("rst_ovf", bus.overflow, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);

        bus.refresh_strobe = 1'b1; tick(1);
        chk("t1_debt1", bus.debt, 1);
        tick(1);
        chk("t1_pre", bus.cmd_precharge_all, 1);
        bus.refresh_strobe = 1'b0;
        tick(TRP);
        chk("t1_ref", bus.cmd_refresh, 1);
        tick(1);
        chk("t1_debt0", bus.debt, 0);
        tick(12);

        bus.user_req = 1'b1; tick(2);
        chk("t2_gnt", bus.user_gnt, 1);
        edges(3);
        chk("t2_debt3", bus.debt, 3);
        chk("t2_gnt_held", bus.user_gnt, 1);
        bus.user_req = 1'b0;
        run(50);
        chk("t2_npre", npre, 1);
        chk("t2_nref", nref, 3);
        chk("t2_debt0", bus.debt, 0);

        bus.user_req = 1'b1; tick(2);
        edges(4);
        chk("t3_debt4", bus.debt, 4);
        bus.user_req = 1'b0; tick(1);
        bus.user_req = 1'b1;
        run(40);
        chk("t3_nref", nref, 1);
        chk("t3_gnt_lat", tg - tr, TRFC + 1);
        chk("t3_debt3", bus.debt, 3);
        bus.user_req = 1'b0;
        run(60);
        chk("t3_drain", nref, 3);

        bus.user_req = 1'b1; tick(2);
        edges(9);
        chk("t4_debt8", bus.debt, 8);
        chk("t4_ovf", bus.overflow, 1);
        chk("t4_gnt", bus.user_gnt, 1);
        bus.user_req = 1'b0;
        run(120);
        chk("t4_nref", nref, 8);
        chk("t4_debt0", bus.debt, 0);
        chk("t4_ovf_sticky", bus.overflow, 1);

        bus.user_req = 1'b1; tick(2);
        edges(2);
        chk("t5_debt2", bus.debt, 2);
        bus.user_req = 1'b0;
        wait_ref("t5_ref_seen");
        bus.refresh_strobe = 1'b1; tick(1);
        chk("t5_incdec", bus.debt, 2);
        bus.refresh_strobe = 1'b0;
        run(40);
        chk("t5_nref", nref, 2);
        chk("t5_debt0", bus.debt, 0);
        bus.enable = 1'b0;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            bus.refresh_strobe = (i % 8) < 4;
            tick(1);
            if (bus.cmd_precharge_all || bus.cmd_refresh || bus.debt != 0) cnt++;
        end
        chk("t5_disabled", cnt, 0);
        bus.refresh_strobe = 1'b0;
        bus.enable = 1'b1; tick(2);

        bus.user_req = 1'b1; tick(2);
        edges(2);
        bus.user_req = 1'b0;
        wait_ref("t6_ref_seen");
        tick(3);
        chk("t6_pre_rst_debt", bus.debt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_debt", bus.debt, 0);
        chk("t6_async_ovf", bus.overflow, 0);
        chk("t6_async_ref", bus.cmd_refresh, 0);
        chk("t6_async_gnt", bus.user_gnt, 0);
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("t6_idle_pre", bus.cmd_precharge_all, 0);
        bus.refresh_strobe = 1'b1; tick(1);
        chk("t6_debt1", bus.debt, 1);
        tick(1);
        chk("t6_restart_pre", bus.cmd_precharge_all, 1);
        bus.refresh_strobe = 1'b0;
        run(30);
        chk("t6_nref", nref, 1);
        chk("t6_debt0", bus.debt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
